ps2_key_decoder: RTL and testbench

Host-side PS/2 line decoder that turns raw keyboard clock/data wires into the 11-bit ps2_key event word that the machine keyboard-matrix block consumes. It synchronises and glitch-filters the lines, deserialises 11-bit frames and checks them, then folds E0/F0 prefixes into extended/release flags. Each complete key event is published by flipping the toggle bit. It sits between the board PS/2 pins (or a test harness) and the keyboard matrix, replacing the HPS-supplied ps2_key source on standalone builds.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_line_filter.sv | 66 ++++++
 rtl/ps2_key_decoder.sv | 189 ++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared constants and types for the PS/2 keyboard decoder:
//   - scancode prefix bytes (extended, release, Pause)
//   - keyboard response / overrun codes that never reach the key matrix
//   - frame state machine encoding
//   - is_response() helper to classify response/overrun bytes
package ps2_pkg;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_REL        = 8'hF0;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;
  localparam logic [2:0] PS2_PAUSE_TAIL = 3'd7;

  localparam logic [7:0] PS2_RESP_BAT    = 8'hAA;
  localparam logic [7:0] PS2_RESP_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESP_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESP_RESEND = 8'hFE;
  localparam logic [7:0] PS2_RESP_OVR0   = 8'h00;
  localparam logic [7:0] PS2_RESP_OVR1   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } frame_state_e;

  function automatic logic is_response(input logic [7:0] b);
    return (b == PS2_RESP_BAT)  || (b == PS2_RESP_ACK)    ||
           (b == PS2_RESP_ECHO) || (b == PS2_RESP_RESEND) ||
           (b == PS2_RESP_OVR0) || (b == PS2_RESP_OVR1);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter
// Conditions one asynchronous PS/2 line: a 2-FF synchroniser followed by a
// run-length filter. The filtered level only changes after FILTER_LEN
// consecutive synchronised samples disagree with it; shorter pulses vanish.
// With FILTER_LEN = 1 the filter collapses to a single register stage.
// Ports:
//   clk_sys  - system clock
//   reset_n  - asynchronous active-low reset (line idles high)
//   line_in  - raw line, asynchronous to clk_sys
//   level    - filtered line level
//   fall     - one-cycle strobe in the first cycle level reads 0 after a 1
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam logic [7:0] RUN_MAX = 8'(FILTER_LEN - 1);

  logic       sync1_q, sync2_q;
  logic       level_q, level_d;
  logic [7:0] run_q, run_d;
  logic       fall_q, fall_d;

  always_comb begin
    level_d = level_q;
    run_d   = run_q;
    fall_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (run_q == RUN_MAX) begin
        level_d = sync2_q;
        run_d   = '0;
        fall_d  = level_q;
      end else begin
        run_d = run_q + 8'd1;
      end
    end else begin
      // Any sample agreeing with the current level restarts the run.
      run_d = '0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      run_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= line_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      run_q   <= run_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Host-side PS/2 keyboard decoder producing the 11-bit ps2_key event word.
// Frames are deserialised on filtered clock falls, checked (start, odd
// parity, stop), and E0/F0/E1 prefixes are folded into flags before a key
// event is published by flipping ps2_key[10].
// Ports:
//   clk_sys     - system clock
//   reset_n     - asynchronous active-low reset
//   ps2_clk_in  - raw PS/2 clock (asynchronous)
//   ps2_data_in - raw PS/2 data (asynchronous)
//   ps2_key     - [7:0] scancode, [8] extended, [9] pressed, [10] toggle
//   frame_err   - one-cycle pulse per rejected or timed-out frame
//   err_count   - saturating count of frame_err pulses
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  import ps2_pkg::*;

  localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic clk_fall;
  logic clk_level_unused;
  logic data_sync;
  logic data_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .line_in (ps2_clk_in),
    .level   (clk_level_unused),
    .fall    (clk_fall)
  );

  // Data needs no debounce: it is only looked at on a filtered clock fall,
  // long after it has settled.
  ps2_line_filter #(.FILTER_LEN(1)) u_data_filter (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .line_in (ps2_data_in),
    .level   (data_sync),
    .fall    (data_fall_unused)
  );

  frame_state_e     state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [10:0]      shift_q, shift_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             ext_q, ext_d;
  logic             rel_q, rel_d;
  logic [2:0]       skip_q, skip_d;
  logic [10:0]      key_q, key_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  // Bits shift in from the top, so after 11 falls shift_q holds
  // {stop, parity, data[7:0], start}.
  logic [7:0] frame_byte;
  logic       frame_ok;
  assign frame_byte = shift_q[8:1];
  assign frame_ok   = ~shift_q[0] & (^shift_q[9:1]) & shift_q[10];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tmo_d       = tmo_q;
    ext_d       = ext_q;
    rel_d       = rel_q;
    skip_d      = skip_q;
    key_d       = key_q;
    frame_err_d = 1'b0;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (clk_fall) begin
          shift_d   = {data_sync, 10'b0};
          bit_cnt_d = 4'd1;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (clk_fall) begin
          tmo_d   = '0;
          shift_d = {data_sync, shift_q[10:1]};
          if (bit_cnt_q == 4'd10) begin
            bit_cnt_d = 4'd0;
            state_d   = CHECK;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
          bit_cnt_d   = 4'd0;
          tmo_d       = '0;
          ext_d       = 1'b0;
          rel_d       = 1'b0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      CHECK: begin
        state_d   = IDLE;
        bit_cnt_d = 4'd0;
        tmo_d     = '0;
        if (!frame_ok) begin
          frame_err_d = 1'b1;
          ext_d       = 1'b0;
          rel_d       = 1'b0;
          skip_d      = 3'd0;
        end else if (skip_q != 3'd0) begin
          skip_d = skip_q - 3'd1;
        end else if (frame_byte == PS2_PAUSE) begin
          skip_d = PS2_PAUSE_TAIL;
        end else if (frame_byte == PS2_EXT) begin
          ext_d = 1'b1;
        end else if (frame_byte == PS2_REL) begin
          rel_d = 1'b1;
        end else if (is_response(frame_byte) && !ext_q && !rel_q) begin
          key_d = key_q;
        end else begin
          key_d = {~key_q[10], ~rel_q, ext_q, frame_byte};
          ext_d = 1'b0;
          rel_d = 1'b0;
        end
        // A fall landing in this cycle is already the next start bit.
        if (clk_fall) begin
          shift_d   = {data_sync, 10'b0};
          bit_cnt_d = 4'd1;
          state_d   = SHIFT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (frame_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      tmo_q       <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      skip_q      <= 3'd0;
      key_q       <= '0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tmo_q       <= tmo_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      skip_q      <= skip_d;
      key_q       <= key_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign ps2_key   = key_q;
  assign frame_err = frame_err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
// Directed bench for ps2_key_decoder with FILTER_LEN = 4, TIMEOUT_CYCLES = 500
// and a 40-cycle PS/2 bit period (clock low for the middle 20 cycles).
module tb_ps2_key_decoder;

  logic        clk_sys     = 1'b0;
  logic        reset_n     = 1'b0;
  logic        ps2_clk_in  = 1'b1;
  logic        ps2_data_in = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic [7:0]  err_count;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          err_pulses   = 0;
  int          key_updates  = 0;
  logic [10:0] last_key     = '0;

  always #5 clk_sys = ~clk_sys;

  ps2_key_decoder #(
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (500)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_key     (ps2_key),
    .frame_err   (frame_err),
    .err_count   (err_count)
  );

  // Observe frame_err pulses and ps2_key changes between clock edges.
  always @(negedge clk_sys) begin
    if (frame_err === 1'b1) err_pulses++;
    if (ps2_key !== last_key) begin
      key_updates++;
      last_key = ps2_key;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One PS/2 bit: data set while clock high, clock low for 20 cycles.
  task automatic sendBit(input logic b);
    ps2_data_in = b;
    repeat (10) @(negedge clk_sys);
    ps2_clk_in = 1'b0;
    repeat (20) @(negedge clk_sys);
    ps2_clk_in = 1'b1;
    repeat (10) @(negedge clk_sys);
  endtask

  // Full 11-bit frame; bad_parity sends even instead of odd parity.
  task automatic applyStimulus(input logic [7:0] b, input logic bad_parity);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(bad_parity ? (^b) : ~(^b));
    sendBit(1'b1);
    repeat (5) @(negedge clk_sys);
  endtask

  initial begin
    int base_upd;
    int base_err;
    logic [7:0] b;
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    // Reset state
    repeat (5) @(negedge clk_sys);
    checkOutput("reset_key", ps2_key, 11'h000);
    checkOutput("reset_frame_err", frame_err, 1'b0);
    checkOutput("reset_err_count", err_count, 8'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);

    // Test 1: 0x1C with latency check. Stop bit driven by hand: the key word
    // should change on the 8th rising edge after the raw clock drops
    // (2 sync + 4 filter + capture + publish).
    b = 8'h1C;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(~(^b));
    ps2_data_in = 1'b1;
    repeat (10) @(negedge clk_sys);
    ps2_clk_in = 1'b0;
    repeat (7) @(negedge clk_sys);
    checkOutput("t1_key_before_latency", ps2_key, 11'h000);
    @(negedge clk_sys);
    checkOutput("t1_key_at_latency", ps2_key, 11'h61C);
    repeat (12) @(negedge clk_sys);
    ps2_clk_in = 1'b1;
    repeat (15) @(negedge clk_sys);
    checkOutput("t1_no_frame_err", err_pulses, 0);

    // Test 2: release of 1C
    base_upd = key_updates;
    applyStimulus(8'hF0, 1'b0);
    checkOutput("t2_no_update_after_f0", key_updates - base_upd, 0);
    applyStimulus(8'h1C, 1'b0);
    checkOutput("t2_key_release", ps2_key, 11'h01C);
    checkOutput("t2_single_update", key_updates - base_upd, 1);

    // Test 3: extended press then extended release
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h75, 1'b0);
    checkOutput("t3_ext_press", ps2_key, 11'h775);
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h75, 1'b0);
    checkOutput("t3_ext_release", ps2_key, 11'h175);

    // Test 4: bad parity after F0 clears the release flag
    base_err = err_pulses;
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h1C, 1'b1);
    checkOutput("t4_key_unchanged", ps2_key, 11'h175);
    checkOutput("t4_err_pulse", err_pulses - base_err, 1);
    checkOutput("t4_err_count", err_count, 8'd1);
    applyStimulus(8'h1C, 1'b0);
    checkOutput("t4_key_pressed", ps2_key, 11'h61C);

    // Test 5a: short glitch on idle clock is ignored
    base_err = err_pulses;
    ps2_clk_in = 1'b0;
    repeat (2) @(negedge clk_sys);
    ps2_clk_in = 1'b1;
    repeat (20) @(negedge clk_sys);
    applyStimulus(8'h29, 1'b0);
    checkOutput("t5_glitch_key", ps2_key, 11'h229);
    checkOutput("t5_glitch_no_err", err_pulses - base_err, 0);

    // Test 5b: frame abandoned after 5 bits times out
    base_err = err_pulses;
    for (int i = 0; i < 5; i++) sendBit(1'b0);
    repeat (600) @(negedge clk_sys);
    checkOutput("t5_timeout_pulse", err_pulses - base_err, 1);
    checkOutput("t5_timeout_count", err_count, 8'd2);
    applyStimulus(8'h29, 1'b0);
    checkOutput("t5_after_timeout_key", ps2_key, 11'h629);

    // Test 6: Pause sequence is swallowed, next key decodes
    base_upd = key_updates;
    for (int i = 0; i < 8; i++) applyStimulus(pause_seq[i], 1'b0);
    checkOutput("t6_pause_no_update", key_updates - base_upd, 0);
    applyStimulus(8'h5A, 1'b0);
    checkOutput("t6_key_5a", ps2_key[9:0], 10'h25A);

    // Test 6b: reset mid-frame discards the partial frame
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    checkOutput("rst_mid_key", ps2_key, 11'h000);
    checkOutput("rst_mid_err_count", err_count, 8'd0);
    checkOutput("rst_mid_frame_err", frame_err, 1'b0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    applyStimulus(8'h1C, 1'b0);
    checkOutput("rst_after_key", ps2_key, 11'h61C);
    checkOutput("rst_after_err_count", err_count, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
